// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bank controller.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StStore,
        StDone
    } state_e;

    localparam int unsigned SpiByteW = 8;
    localparam logic [SpiByteW-1:0] FillOnes  = 8'hFF;
    localparam logic [SpiByteW-1:0] FillZeros = 8'h00;

    // all-ones wins over all-zeros, which wins over bank data
    function automatic logic [SpiByteW-1:0] fill_byte(input logic ones,
                                                      input logic zeros,
                                                      input logic [SpiByteW-1:0] data);
        if (ones) begin
            return FillOnes;
        end else if (zeros) begin
            return FillZeros;
        end
        return data;
    endfunction

endpackage

// File: rtl/module_spi_sclk_gen.sv
// SCLK generator: CLK_DIV clk_i cycles per half-period, idles low while disabled.
// rise_o/fall_o flag the cycle whose closing edge makes sclk_o rise/fall.
module module_spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    logic [15:0] cnt_q;
    logic        sclk_q;
    logic        tick;

    assign tick   = en_i && (cnt_q == 16'(CLK_DIV - 1));
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (tick) begin
            cnt_q  <= '0;
            sclk_q <= !sclk_q;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/module_control_spi.sv
// SPI mode-0 master that streams register-bank words out and stores received bytes back.
// Define SPI_LOOPBACK_EN to feed mosi_o back as the internal MISO (miso_i ignored).
module module_control_spi
    import spi_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [N-1:0]          n_tx_i,
    input  logic                  all_ones_i,
    input  logic                  all_zeros_i,
    input  logic [DATA_WIDTH-1:0] data_rd_i,
    output logic [N-1:0]          addr_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] data_wr_o,
    output logic                  hold_ctrl_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sclk_o,
    output logic                  cs_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    state_e                  state_q;
    logic [N-1:0]            idx_q;
    logic [N-1:0]            n_tx_q;
    logic                    ones_q;
    logic                    zeros_q;
    logic [SpiByteW-1:0]     tx_q;
    logic [SpiByteW-1:0]     rx_q;
    logic [2:0]              bit_cnt_q;
    logic                    wr_q;
    logic                    done_q;
    logic                    cs_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   data_wr_q;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    miso_int;

    logic unused_rd;
    assign unused_rd = ^data_rd_i[DATA_WIDTH-1:SpiByteW];

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign miso_int    = tx_q[SpiByteW-1];
`else
    assign miso_int = miso_i;
`endif

    module_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == StShift),
        .sclk_o (sclk_o),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            n_tx_q    <= '0;
            ones_q    <= 1'b0;
            zeros_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            data_wr_q <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLoad;
                        idx_q   <= '0;
                        n_tx_q  <= n_tx_i;
                        ones_q  <= all_ones_i;
                        zeros_q <= all_zeros_i;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    tx_q      <= fill_byte(ones_q, zeros_q, data_rd_i[SpiByteW-1:0]);
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    if (sclk_rise) begin
                        rx_q <= {rx_q[SpiByteW-2:0], miso_int};
                    end
                    if (sclk_fall) begin
                        tx_q      <= {tx_q[SpiByteW-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        // Eighth falling edge closes the byte; rx_q is already complete.
                        if (bit_cnt_q == 3'(SpiByteW - 1)) begin
                            state_q   <= StStore;
                            wr_q      <= 1'b1;
                            data_wr_q <= DATA_WIDTH'(rx_q);
                        end
                    end
                end
                StStore: begin
                    if (idx_q == n_tx_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        cs_q    <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + N'(1);
                        state_q <= StLoad;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign addr_o      = idx_q;
    assign wr_o        = wr_q;
    assign data_wr_o   = data_wr_q;
    assign hold_ctrl_o = busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cs_o        = cs_q;
    assign mosi_o      = tx_q[SpiByteW-1];

endmodule

// File: tb/tb_module_control_spi.sv
// Directed bench for module_control_spi with a 4-word bank model and per-cycle monitoring.
module tb_module_control_spi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  n_tx_i = '0;
    logic        all_ones_i = 1'b0;
    logic        all_zeros_i = 1'b0;
    logic [31:0] data_rd_i;
    logic [1:0]  addr_o;
    logic        wr_o;
    logic [31:0] data_wr_o;
    logic        hold_ctrl_o;
    logic        busy_o;
    logic        done_o;
    logic        sclk_o;
    logic        cs_o;
    logic        mosi_o;
    logic        miso_i;

    logic [31:0] bank [4];
    logic        loop_mode = 1'b0;
    logic        miso_val = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;
    int          mosi_cnt;
    int          wr_cnt;
    int          done_cnt;
    int          hold_err;
    int          cs_err;
    logic [31:0] mosi_bits;
    logic [7:0]  wr_addr_log;
    logic        sclk_prev;

    assign data_rd_i = bank[addr_o];
    assign miso_i    = loop_mode ? mosi_o : miso_val;

    always #5 clk_i = ~clk_i;

    module_control_spi #(
        .N          (2),
        .DATA_WIDTH (32),
        .CLK_DIV    (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .n_tx_i      (n_tx_i),
        .all_ones_i  (all_ones_i),
        .all_zeros_i (all_zeros_i),
        .data_rd_i   (data_rd_i),
        .addr_o      (addr_o),
        .wr_o        (wr_o),
        .data_wr_o   (data_wr_o),
        .hold_ctrl_o (hold_ctrl_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sclk_o      (sclk_o),
        .cs_o        (cs_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one transaction for a fixed number of cycles, monitoring at every negedge.
    task automatic run_txn(input logic [1:0] n, input logic ones, input logic zeros,
                           input logic loop, input logic miso, input int pulse_at,
                           input int rst_at, input int cycles);
        loop_mode   = loop;
        miso_val    = miso;
        lat         = 0;
        mosi_cnt    = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        hold_err    = 0;
        cs_err      = 0;
        mosi_bits   = '0;
        wr_addr_log = '0;
        sclk_prev   = 1'b0;
        @(negedge clk_i);
        n_tx_i      = n;
        all_ones_i  = ones;
        all_zeros_i = zeros;
        start_i     = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk_i);
            if (sclk_o && !sclk_prev) begin
                mosi_bits = {mosi_bits[30:0], mosi_o};
                mosi_cnt++;
            end
            sclk_prev = sclk_o;
            if (wr_o) begin
                bank[addr_o] = data_wr_o;
                wr_cnt++;
                wr_addr_log = {wr_addr_log[5:0], addr_o};
            end
            if (done_o) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
            if (busy_o !== hold_ctrl_o) hold_err++;
            if (busy_o && !done_o && cs_o) cs_err++;
            if (c == rst_at + 1) begin
                check_eq("rst_mid_cs", cs_o, 1);
                check_eq("rst_mid_busy", busy_o, 0);
                check_eq("rst_mid_sclk", sclk_o, 0);
                rst_i = 1'b0;
            end
            start_i = (c == pulse_at);
            if (c == 1) begin
                n_tx_i      = ~n;
                all_ones_i  = ~ones;
                all_zeros_i = ~zeros;
            end
            if (c == rst_at) rst_i = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bank[i] = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_cs", cs_o, 1);
        check_eq("rst_sclk", sclk_o, 0);
        check_eq("rst_mosi", mosi_o, 0);
        check_eq("rst_wr", wr_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_hold", hold_ctrl_o, 0);
        check_eq("rst_addr", addr_o, 0);
        check_eq("rst_data_wr", data_wr_o, 0);
        rst_i = 1'b0;

        // Single word, MISO held high
        bank[0] = 32'h0000_00A5;
        run_txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -5, 65);
        check_eq("w1_latency", lat, 35);
        check_eq("w1_mosi", mosi_bits[7:0], 8'hA5);
        check_eq("w1_bits", mosi_cnt, 8);
        check_eq("w1_bank0", bank[0], 32'h0000_00FF);
        check_eq("w1_wr_cnt", wr_cnt, 1);
        check_eq("w1_done_cnt", done_cnt, 1);
        check_eq("w1_hold", hold_err, 0);
        check_eq("w1_idle_sclk", sclk_o, 0);

        // Four words looped back: bank must be unchanged
        bank[0] = 32'h11; bank[1] = 32'h22; bank[2] = 32'h33; bank[3] = 32'h44;
        run_txn(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, -1, -5, 170);
        check_eq("lb_latency", lat, 137);
        check_eq("lb_mosi", mosi_bits, 32'h1122_3344);
        check_eq("lb_bits", mosi_cnt, 32);
        check_eq("lb_bank0", bank[0], 32'h11);
        check_eq("lb_bank1", bank[1], 32'h22);
        check_eq("lb_bank2", bank[2], 32'h33);
        check_eq("lb_bank3", bank[3], 32'h44);
        check_eq("lb_wr_cnt", wr_cnt, 4);
        check_eq("lb_wr_addrs", wr_addr_log, 8'h1B);
        check_eq("lb_cs_low", cs_err, 0);
        check_eq("lb_hold", hold_err, 0);
        check_eq("lb_done_cnt", done_cnt, 1);

        // Both fill flags: ones wins, MISO low clears the bank
        bank[0] = 32'h5A; bank[1] = 32'h3C;
        run_txn(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -5, 100);
        check_eq("fill_latency", lat, 69);
        check_eq("fill_mosi", mosi_bits[15:0], 16'hFFFF);
        check_eq("fill_bits", mosi_cnt, 16);
        check_eq("fill_bank0", bank[0], 32'h0);
        check_eq("fill_bank1", bank[1], 32'h0);

        // Zeros fill only
        bank[0] = 32'hC3;
        run_txn(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -5, 65);
        check_eq("zero_mosi", mosi_bits[7:0], 8'h00);
        check_eq("zero_bits", mosi_cnt, 8);
        check_eq("zero_bank0", bank[0], 32'hFF);

        // start_i pulsed mid-transfer is ignored
        bank[0] = 32'h3C;
        run_txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10, -5, 80);
        check_eq("restart_done_cnt", done_cnt, 1);
        check_eq("restart_latency", lat, 35);
        check_eq("restart_wr_cnt", wr_cnt, 1);
        check_eq("restart_mosi", mosi_bits[7:0], 8'h3C);
        check_eq("restart_bank0", bank[0], 32'h0);

        // Reset during SHIFT aborts without a write
        bank[0] = 32'h77;
        run_txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 10, 60);
        check_eq("abort_wr_cnt", wr_cnt, 0);
        check_eq("abort_done_cnt", done_cnt, 0);
        check_eq("abort_bank0", bank[0], 32'h77);
        check_eq("abort_hold", hold_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_control_spi.md
MODULE_CONTROL_SPI -- requirements
Module: module_control_spi

Interface
REQ-001 SHALL have parameter N, default 2, meaning register-bank address width (2**N words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register-bank word width.
REQ-003 SHALL have parameter CLK_DIV, default 2, meaning clk_i cycles per SCLK half-period (>=1).
REQ-004 SHALL have port clk_i  in  1  system clock.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  request to begin a transaction.
REQ-007 SHALL have port n_tx_i  in  N  number of words minus one (n_tx_i+1 words are sent).
REQ-008 SHALL have port all_ones_i  in  1  transmit 0xFF instead of bank data.
REQ-009 SHALL have port all_zeros_i  in  1  transmit 0x00 instead of bank data.
REQ-010 SHALL have port data_rd_i  in  DATA_WIDTH  read data from the bank interface port.
REQ-011 SHALL have port addr_o  out  N  bank interface-port pointer.
REQ-012 SHALL have port wr_o  out  1  bank interface-port write enable.
REQ-013 SHALL have port data_wr_o  out  DATA_WIDTH  received word for the bank.
REQ-014 SHALL have port hold_ctrl_o  out  1  blocks client writes to the bank while high.
REQ-015 SHALL have port busy_o  out  1  transaction in progress.
REQ-016 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-017 SHALL have ports sclk_o, cs_o, mosi_o (out, 1 bit each) and miso_i (in, 1 bit) for SPI mode 0, with cs_o active-low.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, SHIFT, STORE and DONE.
REQ-019 IDLE: cs_o=1, sclk_o=0, busy_o=0, hold_ctrl_o=0; start_i=1 -> LOAD, with the word index cleared to 0.
REQ-020 LOAD (1 cycle): addr_o=index; the TX byte is loaded from all_ones_i ? 0xFF : all_zeros_i ? 0x00 : data_rd_i[7:0]; cs_o goes to 0; -> SHIFT.
REQ-021 SHIFT: 8 SCLK periods of 2*CLK_DIV cycles each, MSB first; mosi_o changes on the SCLK falling edge (the first bit is valid from entry to SHIFT); miso_i is sampled on the rising edge.
REQ-022 SHIFT SHALL last exactly 16*CLK_DIV cycles, end with sclk_o=0, and then go to STORE.
REQ-023 STORE (1 cycle): wr_o=1, addr_o=index, data_wr_o = the RX byte zero-extended to DATA_WIDTH.
REQ-024 STORE exit: if index==n_tx_i -> DONE; otherwise index+1 -> LOAD, with cs_o kept low between words.
REQ-025 DONE (1 cycle): done_o=1, cs_o=1; -> IDLE.
REQ-026 busy_o and hold_ctrl_o SHALL be 1 in every state except IDLE.
REQ-027 Per-word latency SHALL be 16*CLK_DIV+2 cycles; a transaction SHALL take (n_tx_i+1)*(16*CLK_DIV+2)+1 cycles from the start_i sample to the done_o pulse.
REQ-028 start_i SHALL be ignored while busy_o=1.
REQ-029 n_tx_i, all_ones_i and all_zeros_i SHALL be captured at the start_i acceptance and held until DONE.
REQ-030 all_ones_i SHALL take priority when it and all_zeros_i are both high.
REQ-031 When n_tx_i = 2**N-1, every bank word SHALL be transferred and the index SHALL NOT wrap.
REQ-032 wr_o SHALL be 0 outside STORE, and done_o SHALL be 0 outside DONE.

Reset
REQ-033 With rst_i=1 at a clk_i edge, the next state SHALL be IDLE, aborting any transfer in progress without a write.
REQ-034 Reset values: cs_o=1, sclk_o=0, mosi_o=0, wr_o=0, done_o=0, busy_o=0, hold_ctrl_o=0, addr_o=0, data_wr_o=0.

Configuration
REQ-035 With SPI_LOOPBACK_EN defined, the internal MISO SHALL be mosi_o and miso_i SHALL be ignored.
REQ-036 Without SPI_LOOPBACK_EN, the internal MISO SHALL be miso_i.

Structure
REQ-037 Package spi_pkg SHALL hold the state enum, the SPI byte width constant (8) and the 0xFF/0x00 fill constants.
REQ-038 Sub-module module_spi_sclk_gen SHALL produce sclk_o plus single-cycle rise and fall strobes from CLK_DIV, enabled only in SHIFT.

Verification
REQ-039 CLK_DIV=2, n_tx_i=0, bank[0]=0xA5, miso held 1 -> mosi_o=10100101 MSB first, bank[0]=0x000000FF, done_o at cycle 35.
REQ-040 SPI_LOOPBACK_EN, n_tx_i=3, bank={0x11,0x22,0x33,0x44} -> bank is unchanged, 4 wr_o pulses at addresses 0..3, and cs_o stays low throughout.
REQ-041 all_ones_i=all_zeros_i=1, n_tx_i=1 -> mosi_o stays 1 for 16 bits.
REQ-042 start_i pulsed at cycle 10 of a running transfer -> no restart, and exactly one done_o pulse.
REQ-043 rst_i=1 mid-SHIFT -> next cycle cs_o=1, busy_o=0, and no wr_o pulse.
REQ-044 While busy_o=1, check hold_ctrl_o=1 every cycle; it SHALL fall together with busy_o on return to IDLE.
